// File: rtl/fp16_pkg.sv
// Shared FP16 field widths, special encodings and operand unpacking
// for the pipelined adder.
package fp16_pkg;
   localparam int          FP16_EXP_W    = 5;
   localparam int          FP16_MAN_W    = 10;
   localparam int          FP16_EXP_BIAS = 15;
   localparam int          FP16_EXP_MAX  = 2 * FP16_EXP_BIAS + 1;
   localparam logic [15:0] FP16_QNAN     = 16'h7E00;
   localparam logic [15:0] FP16_PINF     = 16'h7C00;

   typedef struct packed {
      logic                  sign;
      logic [FP16_EXP_W-1:0] exp;
      logic [FP16_MAN_W-1:0] man;
      logic                  is_nan;
      logic                  is_inf;
      logic                  is_zero;
   } fp16_unpacked_t;

   // Subnormals are reported as zero with a cleared mantissa (flush-to-zero).
   function automatic fp16_unpacked_t fp16_unpack(input logic [15:0] x);
      fp16_unpacked_t u;
      u.sign    = x[15];
      u.exp     = x[14:10];
      u.man     = x[9:0];
      u.is_nan  = (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
      u.is_inf  = (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
      u.is_zero = (x[14:10] == 5'd0);
      if (u.is_zero) u.man = '0;
      return u;
   endfunction
endpackage

// File: rtl/fp16_add_lane.sv
// One FP16 add/sub lane: S1 aligns the smaller operand, S2 adds,
// normalizes, rounds to nearest-even and packs.
module fp16_add_lane
   import fp16_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        sub,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] y
);
   fp16_unpacked_t ua, ub;
   logic [15:0] b_eff;
   logic        swap;
   logic [10:0] sig_a, sig_b, small_sig;
   logic [4:0]  big_exp, small_exp, diff;
   logic [41:0] wide;
   logic [13:0] small_al;
   logic        nan_c, inf_c;

   logic [15:0] s1_a, s1_b;
   logic        s1_swap, s1_nan, s1_inf;
   logic [13:0] s1_small;

   assign b_eff = {b[15] ^ sub, b[14:0]};

   always_comb begin
      ua        = fp16_unpack(a);
      ub        = fp16_unpack(b_eff);
      sig_a     = ua.is_zero ? 11'd0 : {1'b1, ua.man};
      sig_b     = ub.is_zero ? 11'd0 : {1'b1, ub.man};
      swap      = {ub.exp, ub.man} > {ua.exp, ua.man};
      big_exp   = swap ? ub.exp : ua.exp;
      small_exp = swap ? ua.exp : ub.exp;
      small_sig = swap ? sig_a : sig_b;
      diff      = big_exp - small_exp;
      // 31 spare low bits guarantee nothing shifted out escapes the sticky OR
      wide      = {small_sig, 31'd0} >> diff;
      small_al  = {wide[41:29], |wide[28:0]};
      nan_c     = ua.is_nan | ub.is_nan | (ua.is_inf & ub.is_inf & (ua.sign ^ ub.sign));
      inf_c     = ua.is_inf | ub.is_inf;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_a     <= '0;
         s1_b     <= '0;
         s1_swap  <= 1'b0;
         s1_small <= '0;
         s1_nan   <= 1'b0;
         s1_inf   <= 1'b0;
      end else if (en) begin
         s1_a     <= a;
         s1_b     <= b_eff;
         s1_swap  <= swap;
         s1_small <= small_al;
         s1_nan   <= nan_c;
         s1_inf   <= inf_c;
      end
   end

   logic [15:0] big, res;
   logic [10:0] big_sig;
   logic        eff_sub, found, up;
   logic [14:0] big_ext, raw;
   logic [13:0] m;
   logic [3:0]  lz;
   logic [6:0]  e, e_r;
   logic [11:0] rnd;
   logic [9:0]  man;

   always_comb begin
      big     = s1_swap ? s1_b : s1_a;
      big_sig = (big[14:10] == 5'd0) ? 11'd0 : {1'b1, big[9:0]};
      eff_sub = s1_a[15] ^ s1_b[15];
      big_ext = {1'b0, big_sig, 3'b000};
      raw     = eff_sub ? (big_ext - {1'b0, s1_small}) : (big_ext + {1'b0, s1_small});
      lz      = 4'd0;
      found   = 1'b0;
      for (int i = 13; i >= 0; i--) begin
         if (!found && raw[i]) begin
            lz    = 4'(13 - i);
            found = 1'b1;
         end
      end
      if (raw[14]) begin
         m = {raw[14:2], |raw[1:0]};
         e = {2'b00, big[14:10]} + 7'd1;
      end else begin
         m = raw[13:0] << lz;
         e = {2'b00, big[14:10]} - {3'b000, lz};
      end
      up  = m[2] & (m[3] | m[1] | m[0]);
      rnd = {1'b0, m[13:3]} + {11'd0, up};
      if (rnd[11]) begin
         e_r = e + 7'd1;
         man = rnd[10:1];
      end else begin
         e_r = e;
         man = rnd[9:0];
      end
      // e_r[6] set means the exponent went negative
      if (s1_nan)                               res = FP16_QNAN;
      else if (s1_inf)                          res = FP16_PINF | {big[15], 15'd0};
      else if (raw == 15'd0)                    res = {~eff_sub & big[15], 15'd0};
      else if (e_r[6] || (e_r == 7'd0))         res = {big[15], 15'd0};
      else if (e_r >= 7'(FP16_EXP_MAX))         res = FP16_PINF | {big[15], 15'd0};
      else                                      res = {big[15], e_r[4:0], man};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  y <= '0;
      else if (en) y <= res;
   end
endmodule

// File: rtl/fp16_add_pipe.sv
// Multi-lane two-stage FP16 adder/subtractor with whole-pipe stall
// handshake and an info sideband travelling with each beat.
module fp16_add_pipe
   import fp16_pkg::*;
#(
   parameter int LANES      = 4,
   parameter int INFO_WIDTH = 23
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_vld,
   output logic                  in_rdy,
   input  logic                  sub,
   input  logic [INFO_WIDTH-1:0] info_in,
   input  logic [16*LANES-1:0]   data0,
   input  logic [16*LANES-1:0]   data1,
   output logic                  out_vld,
   input  logic                  out_rdy,
   output logic [INFO_WIDTH-1:0] info_out,
   output logic [16*LANES-1:0]   sum
);
   logic                  s1_vld, s2_vld;
   logic [INFO_WIDTH-1:0] s1_info;

   // Both stages advance together whenever the output slot is free or draining
   assign in_rdy  = !s2_vld || out_rdy;
   assign out_vld = s2_vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld   <= 1'b0;
         s2_vld   <= 1'b0;
         s1_info  <= '0;
         info_out <= '0;
      end else if (in_rdy) begin
         s1_vld   <= in_vld;
         s2_vld   <= s1_vld;
         s1_info  <= info_in;
         info_out <= s1_info;
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      fp16_add_lane u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (in_rdy),
         .sub   (sub),
         .a     (data0[16*i +: 16]),
         .b     (data1[16*i +: 16]),
         .y     (sum[16*i +: 16])
      );
   end
endmodule

// File: tb/tb_fp16_add_pipe.sv
// Scoreboard bench for fp16_add_pipe: directed special cases, backpressure,
// mid-stream reset and a randomized run against an integer-arithmetic model.
module tb_fp16_add_pipe;
   localparam int LANES = 4;
   localparam int IW    = 23;
   localparam int DW    = 16 * LANES;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          in_vld = 1'b0, in_rdy, sub = 1'b0;
   logic          out_vld, out_rdy = 1'b1;
   logic [IW-1:0] info_in = '0, info_out;
   logic [DW-1:0] data0 = '0, data1 = '0, sum;

   int errors = 0, checks = 0, cyc = 0, rdy_mode = 0, bp_base = 0, retired = 0;
   bit seen_bp = 1'b0;

   typedef struct {
      logic [DW-1:0] sum;
      logic [IW-1:0] info;
      int            acc;
      bit            chk_lat;
   } exp_t;
   exp_t sb[$];

   fp16_add_pipe #(.LANES(LANES), .INFO_WIDTH(IW)) dut (
      .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .sub(sub),
      .info_in(info_in), .data0(data0), .data1(data1), .out_vld(out_vld),
      .out_rdy(out_rdy), .info_out(info_out), .sum(sum)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc++;
      #1;
      case (rdy_mode)
         1:       out_rdy = ($urandom_range(0, 99) < 65);
         2:       out_rdy = !(((cyc - bp_base) >= 3) && ((cyc - bp_base) <= 6));
         default: out_rdy = 1'b1;
      endcase
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Reference model: exact sum in units of 2^-24, then RNE to 11 bits
   function automatic bit f_nan(input logic [15:0] x);
      return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
   endfunction
   function automatic bit f_inf(input logic [15:0] x);
      return (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
   endfunction
   function automatic longint f_val(input logic [15:0] x);
      longint v;
      int     ex;
      if (x[14:10] == 5'd0) return 0;
      ex = int'(x[14:10]);
      v  = longint'({1'b1, x[9:0]}) <<< (ex - 1);
      return x[15] ? -v : v;
   endfunction
   function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b_raw, input logic s);
      logic [15:0] b;
      longint      tot, m, q, rem, half;
      int          sh;
      bit          neg;
      logic [4:0]  be;
      b = b_raw;
      b[15] = b_raw[15] ^ s;
      if (f_nan(a) || f_nan(b)) return 16'h7E00;
      if (f_inf(a) && f_inf(b)) return (a[15] == b[15]) ? a : 16'h7E00;
      if (f_inf(a)) return a;
      if (f_inf(b)) return b;
      tot = f_val(a) + f_val(b);
      if (tot == 0) return (a[15] == b[15]) ? {a[15], 15'd0} : 16'h0000;
      neg = (tot < 0);
      m   = neg ? -tot : tot;
      if (m < 1024) return {neg, 15'd0};
      sh = 0;
      while ((m >>> sh) >= 2048) sh++;
      q   = m >>> sh;
      rem = m - (q <<< sh);
      if (sh > 0) begin
         half = longint'(1) <<< (sh - 1);
         if ((rem > half) || ((rem == half) && q[0])) q++;
      end
      if (q == 2048) begin
         q = 1024;
         sh++;
      end
      if (sh + 1 >= 31) return {neg, 15'h7C00};
      be = 5'(sh + 1);
      return {neg, be, q[9:0]};
   endfunction
   function automatic logic [DW-1:0] ref_beat(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s);
      logic [DW-1:0] r;
      for (int i = 0; i < LANES; i++) r[16*i +: 16] = ref_add(a[16*i +: 16], b[16*i +: 16], s);
      return r;
   endfunction

   logic [15:0] specials[10] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00,
                                 16'h0001, 16'h7BFF, 16'hFBFF, 16'h0400, 16'h8400};
   function automatic logic [15:0] rand_op();
      logic [31:0] r;
      r = $urandom();
      if (r[31:29] == 3'd0) return specials[$urandom_range(0, 9)];
      return r[15:0];
   endfunction
   function automatic logic [15:0] near_op(input logic [15:0] x);
      logic [31:0] r;
      r = $urandom();
      return {r[15], x[14:10] ^ {4'b0000, r[10]}, r[9:0]};
   endfunction

   task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s,
                       input logic [IW-1:0] inf, input logic [DW-1:0] req, input bit lat);
      exp_t e;
      int   n = 0;
      data0 = a; data1 = b; sub = s; info_in = inf; in_vld = 1'b1;
      forever begin
         @(negedge clk);
         if (in_rdy) begin
            e.sum = req; e.info = inf; e.acc = cyc; e.chk_lat = lat;
            sb.push_back(e);
            break;
         end
         n++;
         if (n > 1000) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_rdy stayed 0, required 1");
            break;
         end
      end
      @(posedge clk); #1;
      in_vld = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 500 && sb.size() != 0; n++) @(posedge clk);
      #1;
      chk("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   logic [DW-1:0] hold_sum;
   logic [IW-1:0] hold_info;
   bit            stalled = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) stalled = 1'b0;
      else begin
         chk("in_rdy", 64'(in_rdy), 64'(!out_vld || out_rdy));
         if (stalled) begin
            chk("stall_vld", 64'(out_vld), 64'd1);
            chk("stall_sum", sum, hold_sum);
            chk("stall_info", 64'(info_out), 64'(hold_info));
         end
         if (out_vld && !in_rdy) seen_bp = 1'b1;
         if (out_vld && out_rdy) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_out: got beat info %h, required no beat", info_out);
            end else begin
               e = sb.pop_front();
               chk("sum", sum, e.sum);
               chk("info", 64'(info_out), 64'(e.info));
               if (e.chk_lat) chk("latency", 64'(cyc - e.acc), 64'd2);
               retired++;
            end
         end
         stalled   = out_vld && !out_rdy;
         hold_sum  = sum;
         hold_info = info_out;
      end
   end

   initial begin
      logic [DW-1:0] a, b;
      logic [31:0]   r;
      int            r0;
      #12;
      chk("rst_out_vld", 64'(out_vld), 64'd0);
      chk("rst_in_rdy", 64'(in_rdy), 64'd1);
      chk("rst_sum", sum, 64'd0);
      chk("rst_info", 64'(info_out), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      send({16'h3555, 16'h3C00, 16'h4000, 16'h3C00}, {16'h3555, 16'hBC00, 16'h3C00, 16'h3C00}, 1'b0,
           23'h12345, {16'h3955, 16'h0000, 16'h4200, 16'h4000}, 1'b1);
      send({16'h7C00, 16'h7BFF, 16'h3C00, 16'h4200}, {16'h7C00, 16'hFBFF, 16'h3C00, 16'h3C00}, 1'b1,
           23'h00001, {16'h7E00, 16'h7C00, 16'h0000, 16'h4000}, 1'b1);
      send({16'h0001, 16'h7E01, 16'h7C00, 16'h7BFF}, {16'h3C00, 16'h3C00, 16'hFC00, 16'h7BFF}, 1'b0,
           23'h00002, {16'h3C00, 16'h7E00, 16'h7E00, 16'h7C00}, 1'b1);
      send({16'h8401, 16'hFC00, 16'h7C00, 16'h8000}, {16'h0400, 16'h7BFF, 16'h3C00, 16'h8000}, 1'b0,
           23'h00003, {16'h8000, 16'hFC00, 16'h7C00, 16'h8000}, 1'b1);
      drain();

      r0 = retired;
      seen_bp = 1'b0;
      bp_base = cyc;
      rdy_mode = 2;
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < LANES; i++) begin
            a[16*i +: 16] = rand_op();
            b[16*i +: 16] = rand_op();
         end
         send(a, b, 1'b0, 23'(k), ref_beat(a, b, 1'b0), 1'b0);
      end
      drain();
      chk("bp_beats", 64'(retired - r0), 64'd8);
      chk("bp_in_rdy_low", 64'(seen_bp), 64'd1);

      rdy_mode = 0;
      send({4{16'h3C00}}, {4{16'h3C00}}, 1'b0, 23'h0AAAA, {4{16'h4000}}, 1'b1);
      send({4{16'h4000}}, {4{16'h3C00}}, 1'b0, 23'h05555, {4{16'h4200}}, 1'b1);
      chk("pre_reset_vld", 64'(out_vld), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("reset_out_vld", 64'(out_vld), 64'd0);
      chk("reset_in_rdy", 64'(in_rdy), 64'd1);
      chk("reset_sum", sum, 64'd0);
      chk("reset_info", 64'(info_out), 64'd0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      send({4{16'h4200}}, {4{16'h3C00}}, 1'b1, 23'h00777, {4{16'h4000}}, 1'b1);
      drain();

      rdy_mode = 1;
      for (int k = 0; k < 10000; k++) begin
         for (int i = 0; i < LANES; i++) begin
            a[16*i +: 16] = rand_op();
            b[16*i +: 16] = ($urandom_range(0, 3) == 0) ? near_op(a[16*i +: 16]) : rand_op();
         end
         r = $urandom();
         send(a, b, r[0], r[31:9], ref_beat(a, b, r[0]), 1'b0);
         if (r[8:6] == 3'd0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
      rdy_mode = 0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fp16_add_pipe.md
# fp16_add_pipe

Pipelined, multi-lane FP16 adder/subtractor with a ready/valid handshake and a per-beat info sideband. Successor to the single-lane combinational adder in the TRANSFORMER datapath (residual add, bias add). Adds registered stages, backpressure, per-beat add/sub mode and defined IEEE special-case handling. Sits between the matmul/softmax outputs and the layer-norm input.

## Interface
- `LANES`, 4: number of independent FP16 lanes per beat.
- `INFO_WIDTH`, 23: sideband width, carried unmodified with each beat.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_vld` input 1: input beat valid.
- `in_rdy` output 1: block accepts a beat when `in_vld && in_rdy`.
- `sub` input 1: 0 computes `data0+data1`; 1 computes `data0-data1`. Applies to all lanes of the beat.
- `info_in` input INFO_WIDTH: beat sideband.
- `data0` input 16*LANES: lane i is `[16i+15:16i]`.
- `data1` input 16*LANES: same packing.
- `out_vld` output 1: result beat valid.
- `out_rdy` input 1: downstream accepts when `out_vld && out_rdy`.
- `info_out` output INFO_WIDTH: sideband of the presented beat.
- `sum` output 16*LANES: per-lane FP16 result.

## Operation
- Two register stages, S1 and S2, each with a valid bit.
  - S1 registers the operands after `sub` is applied. `sub` inverts bit 15 of each `data1` lane.
  - S1 also registers the align result: larger-magnitude operand, exponent difference, and aligned mantissa with guard/round/sticky bits.
  - S2 registers the add/subtract, normalize, round and pack result. `sum`, `info_out` and `out_vld` come straight from S2 flops.
- Arithmetic per lane:
  - Round-to-nearest-even.
  - Subnormal inputs flush to zero, keeping their sign.
  - A result below the normal range flushes to zero, keeping its sign.
  - A finite overflow gives a signed infinity (0x7C00 or 0xFC00).
  - Any NaN input gives 0x7E00.
  - +inf plus -inf gives 0x7E00.
  - inf plus a finite value gives that inf.
  - An exact-zero result from operands of opposite sign gives +0 (0x0000).
  - -0 plus -0 gives 0x8000.
- Handshake (whole-pipe stall, no skid buffer):
  - `in_rdy = !out_vld || out_rdy`. This is combinational from `out_vld`/`out_rdy` only, with no path from `in_vld`.
  - When `in_rdy` is 1, S1 loads the input beat (valid = `in_vld`) and S2 loads S1.
  - When `in_rdy` is 0, both stages hold.
  - Bubbles therefore advance only when the output is free or drained. This is accepted; utilisation is 100% when `out_rdy` is held at 1.
- `out_vld`, `sum` and `info_out` stay stable while `out_vld && !out_rdy`.
- Lanes are independent: a special case in one lane does not affect the other lanes.

## Timing
- Latency is 2 cycles. A beat accepted at edge N is presented on `out_vld` after edge N+1. It is visible in the cycle between N+1 and N+2, provided no stall occurs.
- Throughput is 1 beat per cycle.
- Reset values, all asynchronous on `rst_n` low:
  - S1 and S2 valid bits = 0, so `out_vld` = 0 and `in_rdy` = 1.
  - `sum` = 0.
  - `info_out` = 0.
  - All S1 data flops = 0.
- Reset asserted mid-stream: every in-flight beat is discarded and nothing is emitted. The first beat after `rst_n` rises follows the normal 2-cycle latency.
- Simultaneous `out_vld && out_rdy` with `in_vld`: the output retires, S2 takes S1 and S1 takes the new beat in the same edge. No beat is lost or duplicated.
- `out_rdy` low while the pipe is empty: `in_rdy` = 1. The pipe fills S1 and then S2, then stalls with 2 beats held.

## Structure
- Package `fp16_pkg`:
  - constants `FP16_QNAN` = 16'h7E00, `FP16_PINF` = 16'h7C00, `FP16_EXP_BIAS` = 15.
  - field widths: exp 5, man 10.
  - a typedef for the unpacked operand (sign, exp, man, is_nan, is_inf, is_zero).
- Sub-module `fp16_add_lane`: one lane, containing the S1 align logic and the S2 normalize/round logic, with a stage-enable input. The top instantiates it `LANES` times with a generate loop and owns the valid bits, the handshake and the `info` registers.

## Test plan
- `LANES`=4 with `out_rdy`=1:
  - lanes (0x3C00+0x3C00, 0x4000+0x3C00, 0x3C00+0xBC00, 0x3555+0x3555) give (0x4000, 0x4200, 0x0000, 0x3955).
  - `info` 0x12345 appears at `info_out` exactly 2 cycles after acceptance.
- `sub`=1 with 0x4200 and 0x3C00 gives 0x4000. `sub`=1 with 0x3C00 and 0x3C00 gives 0x0000.
- Special cases:
  - 0x7BFF+0x7BFF gives 0x7C00.
  - 0x7C00+0xFC00 gives 0x7E00.
  - 0x7E01+0x3C00 gives 0x7E00.
  - 0x0001+0x3C00 gives 0x3C00 (subnormal input flushed).
  - 0x8000+0x8000 gives 0x8000.
- Backpressure:
  - Stream 8 beats with `info` values 0..7.
  - Hold `out_rdy`=0 for cycles 3-6.
  - Required response: `in_rdy` drops while `out_vld` is 1; outputs stay stable; all 8 beats emerge in order with no duplicates.
- Reset: pull `rst_n` low with 2 beats in flight. Required response: `out_vld` goes 0 immediately (asynchronously), the 2 beats never appear, and a post-reset beat appears 2 cycles after acceptance.
- Random: 10k beats with random `out_rdy` and random operands, checked against the reference model using the same FTZ and NaN rules. Required response: bit-exact `sum` and `info_out` for every beat, in order.
